// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address-generation unit: FSM state encoding,
// twiddle unity scaling and the bit-reverse helper.
// Optional feature macro: FFT_AGU_BITREV_EN (adds the bit-reverse LOAD state).
package fft_pkg;

    // Largest supported log2(N); sizes the bit-reverse helper.
    localparam int MAX_LOG2N = 12;

    // Unity magnitude of a twiddle component at the default 16-bit width.
    localparam int TW_UNITY_DEFAULT = 1 << 14;

    // Unity magnitude of a twiddle component for an arbitrary width dw.
    function automatic int tw_unity(input int dw);
        return 1 << (dw - 2);
    endfunction

`ifdef FFT_AGU_BITREV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fft_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fft_state_t;
`endif

    // Reverse the low 'width' bits of v; upper result bits are zero.
    function automatic logic [MAX_LOG2N-1:0] bit_reverse(input logic [MAX_LOG2N-1:0] v,
                                                         input int width);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < width) begin
                r = {r[MAX_LOG2N-2:0], v[i]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle table W_N^k for k = 0..N/2-1, built at elaboration from cos/sin.
// One-cycle registered read; 'clear' forces zero (load beats, idle) and
// 'conj' negates the imaginary part for the inverse transform.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N = 4,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 conj,
    input  logic [LOG2N-2:0]     k,
    output logic signed [DW-1:0] tw_re,
    output logic signed [DW-1:0] tw_im
);

    localparam int  HALF = 1 << (LOG2N - 1);
    localparam real PI   = 3.14159265358979323846;

    // Round half away from zero.
    function automatic int round_to_int(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int cos_q(input int idx);
        real ang;
        ang = 2.0 * PI * real'(idx) / real'(1 << LOG2N);
        return round_to_int(real'(tw_unity(DW)) * $cos(ang));
    endfunction

    // Forward twiddle is exp(-j*ang), so the stored imaginary part is -sin.
    function automatic int nsin_q(input int idx);
        real ang;
        ang = 2.0 * PI * real'(idx) / real'(1 << LOG2N);
        return -round_to_int(real'(tw_unity(DW)) * $sin(ang));
    endfunction

    logic signed [DW-1:0] tab_re [HALF];
    logic signed [DW-1:0] tab_im [HALF];

    for (genvar i = 0; i < HALF; i++) begin : g_tab
        localparam int RE = cos_q(i);
        localparam int IM = nsin_q(i);
        assign tab_re[i] = DW'(RE);
        assign tab_im[i] = DW'(IM);
    end

    // Registered table read with clear and conjugate control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_re <= '0;
            tw_im <= '0;
        end else if (clear) begin
            tw_re <= '0;
            tw_im <= '0;
        end else begin
            tw_re <= tab_re[k];
            tw_im <= conj ? -tab_im[k] : tab_im[k];
        end
    end

endmodule

// File: rtl/fft_agu.sv
// Radix-2 DIT FFT address generator: emits one butterfly beat per handshake
// (stage-major, butterfly index ascending) with operand addresses and the
// matching twiddle. Optional feature macro FFT_AGU_BITREV_EN prepends N
// bit-reverse load beats before the butterfly stages.
//
// Handshake: a beat on out_* transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready low, every
// out_* signal holds. out_valid never drops without a transfer except on rst.
module fft_agu
    import fft_pkg::*;
#(
    parameter  int LOG2N = 4,
    parameter  int DW    = 16,
    localparam int SW    = (LOG2N > 2) ? $clog2(LOG2N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 inv,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_stage,
    output logic [LOG2N-1:0]     out_addr_a,
    output logic [LOG2N-1:0]     out_addr_b,
    output logic signed [DW-1:0] out_tw_re,
    output logic signed [DW-1:0] out_tw_im,
    output logic                 out_load,
    output logic                 out_last,
    output fft_state_t           dbg_state
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;

    fft_state_t       state, state_nxt;
    logic [LOG2N-1:0] cnt;
    logic             inv_q;

    // Next-beat description; equals the current beat when nothing moves.
    logic             n_valid;
    logic [SW-1:0]    n_s;
    logic [LOG2N-1:0] n_cnt;
    logic             n_inv;

    logic             fire;
    logic [LOG2N-1:0] d_a, d_b;
    logic             d_last;
    logic [LOG2N-2:0] rom_k;
    logic             rom_clear;

`ifdef FFT_AGU_BITREV_EN
    logic             load_q;
    logic             n_load;
    assign out_load = load_q;
`else
    assign out_load = 1'b0;
`endif

    assign fire      = out_valid & out_ready;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next beat counters.
    always_comb begin
        state_nxt = state;
        n_valid   = out_valid;
        n_s       = out_stage;
        n_cnt     = cnt;
        n_inv     = inv_q;
`ifdef FFT_AGU_BITREV_EN
        n_load    = load_q;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    n_valid = 1'b1;
                    n_s     = '0;
                    n_cnt   = '0;
                    n_inv   = inv;
`ifdef FFT_AGU_BITREV_EN
                    state_nxt = ST_LOAD;
                    n_load    = 1'b1;
`else
                    state_nxt = ST_RUN;
`endif
                end
            end
`ifdef FFT_AGU_BITREV_EN
            ST_LOAD: begin
                if (fire) begin
                    if (cnt == LOG2N'(N - 1)) begin
                        state_nxt = ST_RUN;
                        n_load    = 1'b0;
                        n_cnt     = '0;
                    end else begin
                        n_cnt = cnt + LOG2N'(1);
                    end
                end
            end
`endif
            ST_RUN: begin
                if (fire) begin
                    if (out_last) begin
                        state_nxt = ST_DONE;
                        n_valid   = 1'b0;
                        n_s       = '0;
                        n_cnt     = '0;
                    end else if (cnt == LOG2N'(HALF - 1)) begin
                        n_cnt = '0;
                        n_s   = out_stage + SW'(1);
                    end else begin
                        n_cnt = cnt + LOG2N'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Addresses, last flag and twiddle index of the next beat.
    always_comb begin
        logic [LOG2N-1:0] span;
        logic [LOG2N-1:0] mask;
        int               sh;
        span      = LOG2N'(1) << n_s;
        mask      = span - LOG2N'(1);
        sh        = LOG2N - 1 - int'(n_s);
        d_a       = '0;
        d_b       = '0;
        d_last    = 1'b0;
        rom_k     = '0;
        rom_clear = 1'b1;
        if (!n_valid) begin
            rom_clear = 1'b1;
        end
`ifdef FFT_AGU_BITREV_EN
        else if (n_load) begin
            d_a = n_cnt;
            d_b = LOG2N'(bit_reverse(MAX_LOG2N'(n_cnt), LOG2N));
        end
`endif
        else begin
            // Insert a zero at bit s of b to get addr_a; addr_b sets that bit.
            d_a       = (((n_cnt >> n_s) << 1) << n_s) | (n_cnt & mask);
            d_b       = d_a | span;
            rom_k     = (LOG2N-1)'(n_cnt & mask) << sh;
            rom_clear = 1'b0;
            d_last    = (n_s == SW'(LOG2N - 1)) && (n_cnt == LOG2N'(HALF - 1));
        end
    end

    // Beat registers; reloaded every cycle so a stall simply reloads the same beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_stage  <= '0;
            out_addr_a <= '0;
            out_addr_b <= '0;
            out_last   <= 1'b0;
            cnt        <= '0;
            inv_q      <= 1'b0;
`ifdef FFT_AGU_BITREV_EN
            load_q     <= 1'b0;
`endif
        end else begin
            out_valid  <= n_valid;
            out_stage  <= n_s;
            out_addr_a <= d_a;
            out_addr_b <= d_b;
            out_last   <= d_last;
            cnt        <= n_cnt;
            inv_q      <= n_inv;
`ifdef FFT_AGU_BITREV_EN
            load_q     <= n_load;
`endif
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
`ifdef FFT_AGU_BITREV_EN
            ST_LOAD: busy = 1'b1;
`endif
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    fft_twiddle_rom #(
        .LOG2N (LOG2N),
        .DW    (DW)
    ) u_rom (
        .clk   (clk),
        .rst   (rst),
        .clear (rom_clear),
        .conj  (n_inv),
        .k     (rom_k),
        .tw_re (out_tw_re),
        .tw_im (out_tw_im)
    );

endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu (LOG2N=4, DW=16), scoreboard based.
module tb_fft_agu;

    localparam int LOG2N = 4;
    localparam int DW    = 16;
    localparam int N     = 16;
    localparam int HALF  = 8;
    localparam int SW    = 2;
    localparam int W     = 44;
`ifdef FFT_AGU_BITREV_EN
    localparam int NLOAD = N;
`else
    localparam int NLOAD = 0;
`endif
    localparam int TOTAL = NLOAD + LOG2N * HALF;
    localparam int OFS   = NLOAD;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 inv;
    logic                 busy;
    logic                 done;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        out_stage;
    logic [LOG2N-1:0]     out_addr_a;
    logic [LOG2N-1:0]     out_addr_b;
    logic signed [DW-1:0] out_tw_re;
    logic signed [DW-1:0] out_tw_im;
    logic                 out_load;
    logic                 out_last;
    logic [1:0]           dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int total_beats = 0;
    int total_dones = 0;
    int xfer_cyc = 0;
    int done_cyc = 0;
    logic done_busy = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    fft_agu #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .inv        (inv),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_stage  (out_stage),
        .out_addr_a (out_addr_a),
        .out_addr_b (out_addr_b),
        .out_tw_re  (out_tw_re),
        .out_tw_im  (out_tw_im),
        .out_load   (out_load),
        .out_last   (out_last),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // scoreboard: compare every transferred beat with the expected queue
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (!rst) begin
            if (done) begin
                total_dones = total_dones + 1;
                done_cyc    = cyc;
                done_busy   = busy;
            end
            if (out_valid && out_ready) begin
                act = {out_load, out_last, out_stage, out_addr_a, out_addr_b, out_tw_re, out_tw_im};
                got_q.push_back(act);
                total_beats = total_beats + 1;
                xfer_cyc    = cyc;
                checks      = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL sb_unexpected_beat got=%h required=none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        failures = failures + 1;
                        $display("FAIL sb_beat n=%0d got=%h required=%h", total_beats, act, exp);
                    end
                end
            end
        end
    end

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    // reference model: push the whole expected beat sequence
    task automatic push_expected(input logic inv_v);
        int span, j, g, a, bb, k, re, im, r;
        real ang;
        logic last;
`ifdef FFT_AGU_BITREV_EN
        for (int n = 0; n < N; n++) begin
            r = 0;
            for (int i = 0; i < LOG2N; i++)
                if ((n & (1 << i)) != 0) r = r | (1 << (LOG2N - 1 - i));
            exp_q.push_back({1'b1, 1'b0, 2'b00, 4'(n), 4'(r), 16'h0000, 16'h0000});
        end
`endif
        for (int s = 0; s < LOG2N; s++) begin
            for (int b = 0; b < HALF; b++) begin
                span = 1 << s;
                j    = b % span;
                g    = b / span;
                a    = g * (2 * span) + j;
                bb   = a + span;
                k    = j * (N / (2 * span));
                ang  = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
                re   = rnd(16384.0 * $cos(ang));
                im   = -rnd(16384.0 * $sin(ang));
                if (inv_v) im = -im;
                last = (s == LOG2N - 1) && (b == HALF - 1);
                exp_q.push_back({1'b0, last, 2'(s), 4'(a), 4'(bb), 16'(re), 16'(im)});
            end
        end
    endtask

    // driver: one-cycle start pulse; inv flipped afterwards to prove it is latched
    task automatic do_start(input logic inv_v);
        push_expected(inv_v);
        @(posedge clk);
        #1 start = 1'b1;
        inv = inv_v;
        @(posedge clk);
        #1 start = 1'b0;
        inv = ~inv_v;
    endtask

    task automatic wait_end(input int budget, input bit rnd_ready, output bit timed_out);
        int d0;
        d0 = total_dones;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (total_dones != d0) begin
                timed_out = 1'b0;
                break;
            end
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [W:0] bundle;
        rst = 1'b1; start = 1'b0; inv = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bundle = {out_valid, out_load, out_last, out_stage, out_addr_a, out_addr_b, out_tw_re, out_tw_im};
        checks++;
        if (bundle !== '0) begin failures++; $display("FAIL reset_outputs got=%h required=0", bundle); end
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b required=00", {busy, done}); end
        checks++;
        if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d required=0", dbg_state); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL idle_no_start got=%b required=00", {out_valid, busy}); end
    endtask

    task automatic test_forward();
        int b0, g0, d0;
        bit to;
        b0 = total_beats; g0 = got_q.size(); d0 = total_dones;
        do_start(1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b11) begin failures++; $display("FAIL first_valid_latency got=%b required=11", {out_valid, busy}); end
        wait_end(200, 1'b0, to);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (to) begin failures++; $display("FAIL fwd_timeout got=timeout required=done"); end
        checks++;
        if (total_beats - b0 != TOTAL) begin failures++; $display("FAIL fwd_beats got=%0d required=%0d", total_beats - b0, TOTAL); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL fwd_leftover got=%0d required=0", exp_q.size()); end
        checks++;
        if (done_cyc != xfer_cyc + 1) begin failures++; $display("FAIL done_timing got=%0d required=%0d", done_cyc, xfer_cyc + 1); end
        checks++;
        if (done_busy !== 1'b0) begin failures++; $display("FAIL busy_at_done got=%b required=0", done_busy); end
        checks++;
        if (total_dones - d0 != 1) begin failures++; $display("FAIL done_pulses got=%0d required=1", total_dones - d0); end
        checks++;
        if (got_q[g0 + OFS][39:0] !== {4'd0, 4'd1, 16'h4000, 16'h0000})
            begin failures++; $display("FAIL s0_b0 got=%h required=%h", got_q[g0 + OFS][39:0], {4'd0, 4'd1, 16'h4000, 16'h0000}); end
        checks++;
        if (got_q[g0 + OFS + 9][39:0] !== {4'd1, 4'd3, 16'h0000, 16'hC000})
            begin failures++; $display("FAIL s1_b1 got=%h required=%h", got_q[g0 + OFS + 9][39:0], {4'd1, 4'd3, 16'h0000, 16'hC000}); end
        checks++;
        if (got_q[g0 + OFS + 25][39:0] !== {4'd1, 4'd9, 16'h3B21, 16'hE782})
            begin failures++; $display("FAIL s3_b1 got=%h required=%h", got_q[g0 + OFS + 25][39:0], {4'd1, 4'd9, 16'h3B21, 16'hE782}); end
        checks++;
        if ({got_q[g0 + TOTAL - 2][42], got_q[g0 + TOTAL - 1][42]} !== 2'b01)
            begin failures++; $display("FAIL last_flag got=%b required=01", {got_q[g0 + TOTAL - 2][42], got_q[g0 + TOTAL - 1][42]}); end
`ifdef FFT_AGU_BITREV_EN
        checks++;
        if ({got_q[g0 + 1][43], got_q[g0 + 1][35:32], got_q[g0 + 6][35:32], got_q[g0 + 11][35:32], got_q[g0 + 16][43]} !== {1'b1, 4'd8, 4'd6, 4'd13, 1'b0})
            begin failures++; $display("FAIL bitrev_load got=%h required=%h",
                {got_q[g0 + 1][43], got_q[g0 + 1][35:32], got_q[g0 + 6][35:32], got_q[g0 + 11][35:32], got_q[g0 + 16][43]},
                {1'b1, 4'd8, 4'd6, 4'd13, 1'b0}); end
`endif
    endtask

    task automatic test_inverse();
        int g0;
        bit to;
        g0 = got_q.size();
        do_start(1'b1);
        wait_end(200, 1'b0, to);
        checks++;
        if (to) begin failures++; $display("FAIL inv_timeout got=timeout required=done"); end
        checks++;
        if (got_q[g0 + OFS + 25][39:0] !== {4'd1, 4'd9, 16'h3B21, 16'h187E})
            begin failures++; $display("FAIL inv_s3_b1 got=%h required=%h", got_q[g0 + OFS + 25][39:0], {4'd1, 4'd9, 16'h3B21, 16'h187E}); end
        checks++;
        if (got_q[g0 + OFS + 17][39:0] !== {4'd1, 4'd5, 16'h2D41, 16'h2D41})
            begin failures++; $display("FAIL inv_s2_b1 got=%h required=%h", got_q[g0 + OFS + 17][39:0], {4'd1, 4'd5, 16'h2D41, 16'h2D41}); end
    endtask

    task automatic test_backpressure();
        int b0, d0;
        bit to;
        logic [W:0] snap, cur;
        b0 = total_beats; d0 = total_dones;
        do_start(1'b0);
        for (int i = 0; i < 200 && (total_beats - b0) < NLOAD + 5; i++) @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        snap = {out_valid, out_load, out_last, out_stage, out_addr_a, out_addr_b, out_tw_re, out_tw_im};
        checks++;
        if (snap[W] !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b required=1", snap[W]); end
        repeat (4) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            cur = {out_valid, out_load, out_last, out_stage, out_addr_a, out_addr_b, out_tw_re, out_tw_im};
            checks++;
            if (cur !== snap) begin failures++; $display("FAIL stall_stable got=%h required=%h", cur, snap); end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_end(200, 1'b0, to);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (to) begin failures++; $display("FAIL bp_timeout got=timeout required=done"); end
        checks++;
        if (total_beats - b0 != TOTAL) begin failures++; $display("FAIL bp_beats got=%0d required=%0d", total_beats - b0, TOTAL); end
        checks++;
        if (total_dones - d0 != 1) begin failures++; $display("FAIL bp_done_pulses got=%0d required=1", total_dones - d0); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int b0, d0;
        bit to;
        logic [W:0] bundle;
        b0 = total_beats; d0 = total_dones;
        do_start(1'b0);
        for (int i = 0; i < 200 && (total_beats - b0) < 10; i++) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        bundle = {out_valid, out_load, out_last, out_stage, out_addr_a, out_addr_b, out_tw_re, out_tw_im};
        checks++;
        if ({bundle, busy, done} !== '0) begin failures++; $display("FAIL mid_reset_outputs got=%h required=0", {bundle, busy, done}); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (total_dones != d0) begin failures++; $display("FAIL mid_reset_no_done got=%0d required=%0d", total_dones, d0); end
        b0 = total_beats;
        do_start(1'b0);
        wait_end(200, 1'b0, to);
        checks++;
        if (to) begin failures++; $display("FAIL restart_timeout got=timeout required=done"); end
        checks++;
        if (total_beats - b0 != TOTAL) begin failures++; $display("FAIL restart_beats got=%0d required=%0d", total_beats - b0, TOTAL); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL restart_leftover got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int b0, d0;
        bit to1, to2;
        b0 = total_beats; d0 = total_dones;
        do_start(1'b0);
        wait_end(600, 1'b1, to1);
        do_start(1'b1);
        wait_end(600, 1'b1, to2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (to1 || to2) begin failures++; $display("FAIL b2b_timeout got=%b%b required=00", to1, to2); end
        checks++;
        if (total_beats - b0 != 2 * TOTAL) begin failures++; $display("FAIL b2b_beats got=%0d required=%0d", total_beats - b0, 2 * TOTAL); end
        checks++;
        if (total_dones - d0 != 2) begin failures++; $display("FAIL b2b_done_pulses got=%0d required=2", total_dones - d0); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_agu.md
FFT_AGU -- requirements
Module: fft_agu

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of FFT size N; legal range 2..12.
REQ-002 SHALL have parameter DW, default 16, meaning signed twiddle component width; unity is 2^(DW-2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin one transform sequence.
REQ-006 SHALL have port inv  input  1  inverse-FFT select, sampled with accepted start.
REQ-007 SHALL have port busy  output  1  high from accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse after final beat handshake.
REQ-009 SHALL have port out_valid  output  1  beat on out_* is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-011 SHALL have port out_stage  output  max(1,clog2(LOG2N))  current butterfly stage s.
REQ-012 SHALL have ports out_addr_a and out_addr_b  output  LOG2N each  butterfly operand addresses.
REQ-013 SHALL have ports out_tw_re and out_tw_im  output  DW each  signed twiddle components.
REQ-014 SHALL have port out_load  output  1  beat is a bit-reverse load beat, not a butterfly.
REQ-015 SHALL have port out_last  output  1  beat is the final beat of the sequence.

Function
REQ-016 SHALL implement FSM IDLE -> (LOAD) -> RUN -> DONE -> IDLE; start accepted only in IDLE, ignored elsewhere.
REQ-017 RUN SHALL emit LOG2N stages x N/2 butterflies, stage-major, butterfly index b ascending from 0.
REQ-018 For stage s, span=2^s, j=b mod span, g=b>>s: addr_a=g*2^(s+1)+j, addr_b=addr_a+span.
REQ-019 Twiddle index k=j<<(LOG2N-1-s); tw_re=round(2^(DW-2)*cos(2*pi*k/N)), tw_im=-round(2^(DW-2)*sin(2*pi*k/N)).
REQ-020 With latched inv=1, tw_im SHALL be negated (conjugate twiddle); tw_re unchanged.
REQ-021 Outputs SHALL be registered; first out_valid one cycle after accepted start.
REQ-022 Beat transfers when out_valid and out_ready both high; next beat appears the following cycle, allowing one beat per cycle at full throughput.
REQ-023 While out_valid high and out_ready low, all out_* SHALL hold stable.
REQ-024 out_last SHALL be high only on the final beat (s=LOG2N-1, b=N/2-1); done pulses the cycle after its transfer, busy falls same cycle.
REQ-025 Counters SHALL wrap b to 0 and increment s at end of each stage; no gap cycles between stages.

Reset
REQ-026 rst SHALL asynchronously force IDLE; busy, done, out_valid, out_load, out_last, out_stage, addresses and twiddles all 0.
REQ-027 rst mid-sequence SHALL abandon the sequence without a done pulse; next start begins from stage 0.

Configuration
REQ-028 Macro FFT_AGU_BITREV_EN, when defined, SHALL add LOAD state before RUN emitting N beats n=0..N-1 with out_load=1, addr_a=n, addr_b=bitreverse(n), twiddles 0.
REQ-029 Without FFT_AGU_BITREV_EN, LOAD SHALL not exist, out_load SHALL be tied 0, and input is assumed already bit-reversed in memory.

Structure
REQ-030 Shared package fft_pkg SHALL hold the FSM state typedef, twiddle-unity constant and the bit-reverse function.
REQ-031 Twiddle table (N/2 entries, computed at elaboration) SHALL be sub-module fft_twiddle_rom, one-cycle registered read.

Verification
REQ-032 LOG2N=4, start, out_ready=1: exactly 32 beats, done 1 cycle after beat 32; stage 0 b=0 -> addr 0/1, tw (16384,0).
REQ-033 Stage 1 b=1 -> addr 1/3, tw (0,-16384); stage 3 b=1 -> addr 1/9, tw (15137,-6270).
REQ-034 inv=1 at start, stage 3 b=1 -> tw (15137,6270); stage 2 b=1 -> tw (11585,11585).
REQ-035 out_ready low 5 cycles mid-stage: out_* stable throughout, no beat lost or repeated; start during busy ignored.
REQ-036 rst asserted at beat 10: outputs 0 immediately, no done; restart yields full 32 beats.
REQ-037 With FFT_AGU_BITREV_EN: 16 load beats precede RUN; n=1 -> addr_b 8, n=6 -> addr_b 6, n=11 -> addr_b 13; 48 beats total.
